vga_timing_gen: RTL and testbench

Generates the 640x480@60 Hz raster for the Pong display: free-running horizontal/vertical counters drive the pixel coordinates `x`/`y` consumed by the image generator. The 3-bit `color` it returns is registered, blanked outside the visible area, and emitted with HSYNC/VSYNC aligned to it. The block also produces a once-per-frame tick for game-logic updates during vertical blanking.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/raster_counter.sv | 51 +++++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, color definitions and small helpers for the Pong display path.
// Imported by the timing generator, the image generator and the ball/player logic.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COLOR_W = 3;
  localparam int COORD_W = 12;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam color_t COLOR_BLACK   = 3'b000;
  localparam color_t COLOR_WHITE   = 3'b111;
  localparam color_t COLOR_PLAYER1 = 3'b001;
  localparam color_t COLOR_PLAYER2 = 3'b100;

  // Everything leaving the output register stage, kept together so it stays aligned.
  typedef struct packed {
    color_t rgb;
    logic   de;
    logic   hs;
    logic   vs;
    logic   tick;
  } vga_out_t;

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Free-running horizontal/vertical raster counters; hc wraps at H_TOTAL-1 and steps vc,
// both wrap together at the last pixel of the frame.
module raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output vga_pkg::coord_t hc_o,
  output vga_pkg::coord_t vc_o,
  output logic            eol_o,
  output logic            eof_o
);
  import vga_pkg::*;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t ONE    = coord_t'(1);

  coord_t hc_q, hc_d;
  coord_t vc_q, vc_d;
  logic   eol, eof;

  assign eol = (hc_q == H_LAST);
  assign eof = eol && (vc_q == V_LAST);

  always_comb begin
    hc_d = hc_q + ONE;
    vc_d = vc_q;
    if (eol) begin
      hc_d = '0;
      vc_d = eof ? '0 : (vc_q + ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o  = hc_q;
  assign vc_o  = vc_q;
  assign eol_o = eol;
  assign eof_o = eof;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: drives x/y to the image generator and registers the returned
// color together with DE, HS, VS and the once-per-frame game tick, all on one output stage.
module vga_timing_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  output logic [11:0] x,
  output logic [11:0] y,
  input  logic [2:0]  color,
  output logic [2:0]  VGA_RGB,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_DE,
  output logic        FRAME_TICK
);
  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
  localparam coord_t H_LAST_VIS = coord_t'(H_ACTIVE - 1);
  localparam coord_t V_LAST_VIS = coord_t'(V_ACTIVE - 1);
  localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam vga_out_t OUT_RESET = '{
    rgb:  COLOR_BLACK,
    de:   1'b0,
    hs:   ~SYNC_ACTIVE,
    vs:   ~SYNC_ACTIVE,
    tick: 1'b0
  };

  coord_t   hc, vc;
  logic     eol, eof;
  logic     visible;
  logic     hs_on, vs_on;
  vga_out_t out_q, out_d;

  raster_counter #(
    .H_TOTAL (H_TOT),
    .V_TOTAL (V_TOT)
  ) u_raster (
    .clk_i  (CLOCK_25),
    .rst_ni (RESET_N),
    .hc_o   (hc),
    .vc_o   (vc),
    .eol_o  (eol),
    .eof_o  (eof)
  );

  // The line/frame strobes are not needed here; the tick fires at end of the visible area.
  logic unused_strobes;
  assign unused_strobes = eol ^ eof;

  assign visible = (hc < H_VIS) && (vc < V_VIS);
  assign hs_on   = in_window(hc, HS_FIRST, HS_LAST);
  assign vs_on   = in_window(vc, VS_FIRST, VS_LAST);

  always_comb begin
    out_d      = OUT_RESET;
    out_d.rgb  = visible ? color : COLOR_BLACK;
    out_d.de   = visible;
    out_d.hs   = hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    out_d.vs   = vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    out_d.tick = (hc == H_LAST_VIS) && (vc == V_LAST_VIS);
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      out_q <= OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign x          = hc;
  assign y          = vc;
  assign VGA_RGB    = out_q.rgb;
  assign VGA_DE     = out_q.de;
  assign VGA_HS     = out_q.hs;
  assign VGA_VS     = out_q.vs;
  assign FRAME_TICK = out_q.tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size instance checks line timing; a shrunk-raster instance covers
// whole frames, ticks and mid-frame reset within a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int SHA = 16, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 32
  localparam int SVT = SVA + SVF + SVS + SVB;   // 19
  localparam int SFRAME = SHT * SVT;            // 608

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        tick;
  } obs_t;

  typedef struct {
    obs_t a;
    obs_t b;
  } exp_t;

  localparam obs_t RST_OBS = '{x: 12'd0, y: 12'd0, rgb: 3'd0, de: 1'b0,
                               hs: 1'b1, vs: 1'b1, tick: 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] xa, ya, xb, yb;
  logic [2:0]  color_a = 3'd0, color_b = 3'd0, rgb_a, rgb_b;
  logic        hs_a, vs_a, de_a, tick_a, hs_b, vs_b, de_b, tick_b;

  vga_timing_gen u_full (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(xa), .y(ya), .color(color_a),
    .VGA_RGB(rgb_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_DE(de_a), .FRAME_TICK(tick_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_ACTIVE(1'b0)
  ) u_small (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(xb), .y(yb), .color(color_b),
    .VGA_RGB(rgb_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_DE(de_b), .FRAME_TICK(tick_b)
  );

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  int ra_h = 0, ra_v = 0, rb_h = 0, rb_v = 0;

  // measurement window statistics
  bit win_on = 1'b0;
  int win_cyc, hsa_low, hsa_first, deb_cnt, vsb_low, hsb_low, tick_cnt, tick_last, gap_bad;
  logic [11:0] xa_799, ya_800;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t act, input obs_t want);
    chk({tag, ".x"},    act.x, want.x);
    chk({tag, ".y"},    act.y, want.y);
    chk({tag, ".rgb"},  12'(act.rgb),  12'(want.rgb));
    chk({tag, ".de"},   12'(act.de),   12'(want.de));
    chk({tag, ".hs"},   12'(act.hs),   12'(want.hs));
    chk({tag, ".vs"},   12'(act.vs),   12'(want.vs));
    chk({tag, ".tick"}, 12'(act.tick), 12'(want.tick));
  endtask

  // Expected outputs after the next edge given the counters currently presented.
  function automatic obs_t predict(input int h, input int v, input int ha, input int hs_lo,
                                   input int hs_w, input int va, input int vs_lo, input int vs_w,
                                   input int ht, input int vt, input logic [2:0] c);
    obs_t o;
    logic vis;
    vis    = (h < ha) && (v < va);
    o.rgb  = vis ? c : 3'd0;
    o.de   = vis;
    o.hs   = !((h >= hs_lo) && (h < hs_lo + hs_w));
    o.vs   = !((v >= vs_lo) && (v < vs_lo + vs_w));
    o.tick = (h == ha - 1) && (v == va - 1);
    o.x    = 12'((h == ht - 1) ? 0 : h + 1);
    o.y    = 12'((h == ht - 1) ? ((v == vt - 1) ? 0 : v + 1) : v);
    return o;
  endfunction

  // mode 0: constant white, 1: color = x[2:0], 2: random color
  task automatic step(input logic rst_v, input int mode);
    exp_t e;
    @(negedge clk);
    rst_n = rst_v;
    case (mode)
      0: begin color_a = 3'b111; color_b = 3'b111; end
      1: begin color_a = 3'(ra_h); color_b = 3'(rb_h); end
      default: begin
        color_a = 3'($urandom_range(0, 7));
        color_b = 3'($urandom_range(0, 7));
      end
    endcase
    if (!rst_v) begin
      e.a = RST_OBS; e.b = RST_OBS;
      ra_h = 0; ra_v = 0; rb_h = 0; rb_v = 0;
    end else begin
      e.a = predict(ra_h, ra_v, 640, 656, 96, 480, 490, 2, 800, 525, color_a);
      e.b = predict(rb_h, rb_v, SHA, SHA + SHF, SHS, SVA, SVA + SVF, SVS, SHT, SVT, color_b);
      ra_h = int'(e.a.x); ra_v = int'(e.a.y);
      rb_h = int'(e.b.x); rb_v = int'(e.b.y);
    end
    sb.push_back(e);
  endtask

  // Called between a monitor sample and the next negedge so the window starts cleanly.
  task automatic open_window();
    @(posedge clk);
    #2;
    win_cyc = 0; hsa_low = 0; hsa_first = 0; deb_cnt = 0; vsb_low = 0; hsb_low = 0;
    tick_cnt = 0; tick_last = 0; gap_bad = 0; xa_799 = '0; ya_800 = '0;
    win_on = 1'b1;
  endtask

  task automatic close_window();
    @(posedge clk);
    #2;
    win_on = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    obs_t oa, ob;
    #1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      oa = {xa, ya, rgb_a, de_a, hs_a, vs_a, tick_a};
      ob = {xb, yb, rgb_b, de_b, hs_b, vs_b, tick_b};
      cmp_obs("full", oa, e.a);
      cmp_obs("small", ob, e.b);
      if (win_on) begin
        win_cyc++;
        if (win_cyc <= 800 && !hs_a) begin
          hsa_low++;
          if (hsa_first == 0) hsa_first = win_cyc;
        end
        if (win_cyc == 799) xa_799 = xa;
        if (win_cyc == 800) ya_800 = ya;
        if (de_b)  deb_cnt++;
        if (!vs_b) vsb_low++;
        if (!hs_b) hsb_low++;
        if (tick_b) begin
          if (tick_cnt > 0 && (win_cyc - tick_last) != SFRAME) gap_bad++;
          tick_cnt++;
          tick_last = win_cyc;
        end
      end
    end
  end

  initial begin
    bit found;
    #1 rst_n = 1'b0;

    // reset held for 5 cycles; scoreboard expects reset values throughout
    for (int i = 0; i < 5; i++) step(1'b0, 0);

    // release, white screen; full-size line timing
    open_window();
    for (int i = 0; i < 1000; i++) step(1'b1, 0);
    close_window();
    chk("full.hs_first_cycle", 12'(hsa_first), 12'd657);
    chk("full.hs_low_cycles", 12'(hsa_low), 12'd96);
    chk("full.x_after_799", xa_799, 12'd799);
    chk("full.y_after_800", ya_800, 12'd1);

    // alignment pattern until the small raster sits inside both HS and VS
    found = 1'b0;
    for (int i = 0; i < 2 * SFRAME && !found; i++) begin
      if (rb_h == 24 && rb_v == 15) found = 1'b1;
      else step(1'b1, 1);
    end
    chk("reach_reset_point", 12'(found), 12'd1);

    // mid-frame asynchronous reset; outputs must drop before any clock edge
    step(1'b0, 1);
    #1;
    chk("midreset.small.hs", 12'(hs_b), 12'd1);
    chk("midreset.small.vs", 12'(vs_b), 12'd1);
    chk("midreset.small.x", xb, 12'd0);
    chk("midreset.small.y", yb, 12'd0);
    chk("midreset.full.hs", 12'(hs_a), 12'd1);
    chk("midreset.full.vs", 12'(vs_a), 12'd1);
    for (int i = 0; i < 2; i++) step(1'b0, 1);

    // three full small frames after restart with random color
    open_window();
    for (int i = 0; i < 3 * SFRAME; i++) step(1'b1, 2);
    close_window();
    chk("small.tick_count", 12'(tick_cnt), 12'd3);
    chk("small.tick_gap_errors", 12'(gap_bad), 12'd0);
    chk("small.first_tick_cycle", 12'(tick_last - 2 * SFRAME), 12'(SVA * SHT - SHT + SHA));
    chk("small.de_cycles", 12'(deb_cnt), 12'(3 * SHA * SVA));
    chk("small.vs_low_cycles", 12'(vsb_low), 12'(3 * SVS * SHT));
    chk("small.hs_low_cycles", 12'(hsb_low), 12'(3 * SVT * SHS));

    // alignment pattern once more over a full frame
    for (int i = 0; i < SFRAME; i++) step(1'b1, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 12'(sb.size()), 12'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
